// File: rtl/bbs_pkg.sv
// Shared definitions for the BBS bit packer and related BBS blocks:
// packer state encoding, drop counter width, default data width and a
// saturating-increment helper for the drop counter.
package bbs_pkg;

  // Default width of the BBS generator state and of the packed word.
  localparam int unsigned BBS_DEFAULT_W = 16;

  // Width of the saturating drop counter.
  localparam int unsigned BBS_DROP_W = 16;

  // Packer states: FILL while the shift register collects bits, STALL while
  // a complete word waits in the shift register behind an occupied output.
  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_STALL = 1'b1
  } bbs_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [BBS_DROP_W-1:0] bbs_sat_inc(
    input logic [BBS_DROP_W-1:0] v
  );
    return (v == '1) ? v : v + BBS_DROP_W'(1);
  endfunction

endpackage

// File: rtl/bbs_vn_debias.sv
// Von Neumann debiaser: consumes raw bits in non-overlapping pairs (a,b).
// A pair with a != b emits a; a pair with a == b emits nothing. The first
// bit of a pair waits in a pending register, which 'clear' discards.
// Output is combinational on the second bit of a pair.
module bbs_vn_debias (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic in_bit,
  input  logic in_valid,
  output logic out_bit,
  output logic out_valid
);

  logic pend_q;
  logic pend_d;
  logic pend_valid_q;
  logic pend_valid_d;

  // Pair tracking and emission decision.
  always_comb begin
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    out_bit      = pend_q;
    out_valid    = 1'b0;
    if (clear) begin
      pend_valid_d = 1'b0;
    end else if (in_valid) begin
      if (pend_valid_q) begin
        pend_valid_d = 1'b0;
        out_valid    = (pend_q != in_bit);
      end else begin
        pend_d       = in_bit;
        pend_valid_d = 1'b1;
      end
    end
  end

  // Pending-bit registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q       <= 1'b0;
      pend_valid_q <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
    end
  end

endmodule

// File: rtl/bbs_bit_packer.sv
// BBS bit packer: extracts bit 0 of each non-zero BBS state sample and packs
// W bits MSB-first into an output word with a valid/ready handshake. When a
// full word cannot be handed to an occupied output register it is held in
// the shift register (STALL) and further samples are dropped and counted.
// Build option: define BBS_PACK_VN_EN to route accepted bits through a von
// Neumann debiaser (bbs_vn_debias) before packing.
module bbs_bit_packer
  import bbs_pkg::*;
#(
  parameter int unsigned W = BBS_DEFAULT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [W-1:0]          in_state,
  input  logic                  in_valid,
  output logic [W-1:0]          out_word,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BBS_DROP_W-1:0] drop_cnt
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  bbs_state_e            state_q;
  bbs_state_e            state_d;
  logic [CW-1:0]         bit_cnt_q;
  logic [CW-1:0]         bit_cnt_d;
  logic [W-1:0]          shift_q;
  logic [W-1:0]          shift_d;
  logic [W-1:0]          out_word_q;
  logic [W-1:0]          out_word_d;
  logic                  out_valid_q;
  logic                  out_valid_d;
  logic [BBS_DROP_W-1:0] drop_cnt_q;
  logic [BBS_DROP_W-1:0] drop_cnt_d;

  logic                  accept;
  logic                  drop;
  logic                  fill_in;
  logic                  pack_bit;
  logic                  pack_valid;
  logic                  handshake;
  logic [W-1:0]          shift_next;

  // Sample qualification: an all-zero state is an unseeded generator and is
  // neither packed nor counted.
  always_comb begin
    accept    = in_valid && (in_state != '0);
    fill_in   = accept && (state_q == ST_FILL);
    drop      = accept && (state_q == ST_STALL);
    handshake = out_valid_q && out_ready;
  end

`ifdef BBS_PACK_VN_EN
  // Raw bits only reach the debiaser in FILL; a drop also discards any
  // half-formed pair so pairing restarts cleanly after the stall.
  bbs_vn_debias u_vn_debias (
    .clk       (clk),
    .reset     (reset),
    .clear     (drop),
    .in_bit    (in_state[0]),
    .in_valid  (fill_in),
    .out_bit   (pack_bit),
    .out_valid (pack_valid)
  );
`else
  // Direct packing of every accepted bit.
  always_comb begin
    pack_bit   = in_state[0];
    pack_valid = fill_in;
  end
`endif

  // Next-state, packing and handshake logic.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    out_word_d  = out_word_q;
    out_valid_d = out_valid_q && !out_ready;
    drop_cnt_d  = drop_cnt_q;
    shift_next  = {shift_q[W-2:0], pack_bit};

    unique case (state_q)
      ST_FILL: begin
        if (pack_valid) begin
          if (bit_cnt_q == CW'(W - 1)) begin
            bit_cnt_d = '0;
            if (!out_valid_q || out_ready) begin
              out_word_d  = shift_next;
              out_valid_d = 1'b1;
              shift_d     = '0;
            end else begin
              shift_d = shift_next;
              state_d = ST_STALL;
            end
          end else begin
            shift_d   = shift_next;
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end

      ST_STALL: begin
        if (drop) begin
          drop_cnt_d = bbs_sat_inc(drop_cnt_q);
        end
        // The held word moves straight into the output register, so the
        // output stays valid across the release.
        if (handshake) begin
          out_word_d  = shift_q;
          out_valid_d = 1'b1;
          shift_d     = '0;
          bit_cnt_d   = '0;
          state_d     = ST_FILL;
        end
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_FILL;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign out_word  = out_word_q;
  assign out_valid = out_valid_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_bbs_bit_packer.sv
// Directed self-checking bench for bbs_bit_packer (W=16). With
// BBS_PACK_VN_EN defined it runs the debiaser pattern; otherwise the direct
// packing, zero-state, stall/drop, back-to-back and reset scenarios.
module tb_bbs_bit_packer;

  localparam int unsigned W = 16;

  logic          clk;
  logic          reset;
  logic [W-1:0]  in_state;
  logic          in_valid;
  logic [W-1:0]  out_word;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   drop_cnt;

  int unsigned n_cmp;
  int unsigned n_err;

  bbs_bit_packer #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_state  (in_state),
    .in_valid  (in_valid),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One sample per cycle; returns #1 after the accepting edge.
  task automatic send(input logic [W-1:0] v);
    in_valid = 1'b1;
    in_state = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_state = '0;
  endtask

  task automatic send_n(input logic [W-1:0] v, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) send(v);
  endtask

  task automatic idle(input int unsigned n);
    in_valid = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset(input string tag);
    #1 reset = 1'b1;
    #1;
    check({tag, "_word"},  32'(out_word),  32'h0);
    check({tag, "_valid"}, 32'(out_valid), 32'h0);
    check({tag, "_drop"},  32'(drop_cnt),  32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Bench stop if anything hangs.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_state  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_word",  32'(out_word),  32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_drop",  32'(drop_cnt),  32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

`ifdef BBS_PACK_VN_EN
    // LSBs 0,1,1,0,1,1,0,0 -> pairs emit 0,1 per group; 16th bit at sample 60.
    out_ready = 1'b0;
    for (int unsigned g = 0; g < 8; g++) begin
      for (int unsigned k = 0; k < 8; k++) begin
        logic [7:0] pat;
        pat = 8'b0110_1100;
        send(pat[7-k] ? 16'd3 : 16'd2);
        if (g == 7 && k == 2) check("vn_pre_valid", 32'(out_valid), 32'h0);
      end
    end
    check("vn_word",  32'(out_word),  32'h5555);
    check("vn_valid", 32'(out_valid), 32'h1);
    check("vn_drop",  32'(drop_cnt),  32'h0);
    // Zero states are ignored by the debiaser path too.
    send_n(16'd0, 4);
    check("vn_zero_drop", 32'(drop_cnt), 32'h0);
    out_ready = 1'b1;
    idle(1);
    check("vn_consumed", 32'(out_valid), 32'h0);
    pulse_reset("vn_rst");
`else
    // Alternating LSB 1,0 -> 16'hAAAA; valid right after the 16th edge.
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 15; i++) send((i % 2 == 0) ? 16'd1 : 16'd2);
    check("alt_pre_valid", 32'(out_valid), 32'h0);
    send(16'd2);
    check("alt_word",  32'(out_word),  32'hAAAA);
    check("alt_valid", 32'(out_valid), 32'h1);
    check("alt_drop",  32'(drop_cnt),  32'h0);

    // Zero states neither pack nor count.
    send_n(16'd0, 20);
    check("zero_valid", 32'(out_valid), 32'h0);
    check("zero_drop",  32'(drop_cnt),  32'h0);
    send_n(16'd3, 15);
    check("three_pre_valid", 32'(out_valid), 32'h0);
    send(16'd3);
    check("three_word",  32'(out_word),  32'hFFFF);
    check("three_valid", 32'(out_valid), 32'h1);
    idle(1);
    check("three_consumed", 32'(out_valid), 32'h0);

    // Backpressure: 16 load, 16 fill and stall, 5 dropped.
    out_ready = 1'b0;
    send_n(16'd5, 16);
    check("bp_first_word",  32'(out_word),  32'hFFFF);
    check("bp_first_valid", 32'(out_valid), 32'h1);
    send_n(16'd5, 21);
    check("bp_word_stable", 32'(out_word),  32'hFFFF);
    check("bp_valid",       32'(out_valid), 32'h1);
    check("bp_drop",        32'(drop_cnt),  32'h5);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    check("bp_rel_word",  32'(out_word),  32'hFFFF);
    check("bp_rel_valid", 32'(out_valid), 32'h1);
    check("bp_rel_drop",  32'(drop_cnt),  32'h5);
    // Back in FILL: this sample is packed, not dropped.
    send(16'd5);
    check("bp_fill_drop", 32'(drop_cnt), 32'h5);

    // 16th bit arrives with the handshake: 1 then fifteen 0s -> 16'h8000.
    send_n(16'd2, 14);
    out_ready = 1'b1;
    send(16'd2);
    out_ready = 1'b0;
    check("b2b_word",  32'(out_word),  32'h8000);
    check("b2b_valid", 32'(out_valid), 32'h1);
    check("b2b_drop",  32'(drop_cnt),  32'h5);
    idle(1);
    check("b2b_hold_valid", 32'(out_valid), 32'h1);
    check("b2b_hold_word",  32'(out_word),  32'h8000);

    // Reset mid-word, then a fresh word needs 16 new samples.
    send_n(16'd1, 8);
    pulse_reset("mid_rst");
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 15; i++) send((i % 2 == 0) ? 16'd1 : 16'd2);
    check("fresh_pre_valid", 32'(out_valid), 32'h0);
    send(16'd2);
    check("fresh_word", 32'(out_word), 32'hAAAA);

    // Stall, drop 2, then a sample on the release cycle is also dropped.
    out_ready = 1'b0;
    send_n(16'd3, 16);
    send_n(16'd3, 2);
    check("st_drop", 32'(drop_cnt), 32'h2);
    check("st_word", 32'(out_word), 32'hAAAA);
    out_ready = 1'b1;
    send(16'd3);
    out_ready = 1'b0;
    check("st_rel_word",  32'(out_word),  32'hFFFF);
    check("st_rel_valid", 32'(out_valid), 32'h1);
    check("st_rel_drop",  32'(drop_cnt),  32'h3);

    // Stall again and reset out of STALL.
    send_n(16'd1, 17);
    check("st2_drop", 32'(drop_cnt), 32'h4);
    pulse_reset("stall_rst");
    idle(2);
    check("post_rst_valid", 32'(out_valid), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bbs_bit_packer.md
BBS_BIT_PACKER -- requirements
Module: bbs_bit_packer

Interface
REQ-001 Parameter: W, 16, width of incoming BBS state and of the packed output word.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: in_state  input  W  BBS generator state x(i), sampled every cycle.
REQ-005 Port: in_valid  input  1  in_state holds a fresh BBS sample this cycle.
REQ-006 Port: out_word  output  W  packed random word.
REQ-007 Port: out_valid  output  1  out_word holds an unconsumed word.
REQ-008 Port: out_ready  input  1  consumer accepts out_word this cycle.
REQ-009 Port: drop_cnt  output  16  saturating count of samples discarded under backpressure.

Function
REQ-010 The block SHALL accept a sample only when in_valid=1 and in_state!=0; zero state (degenerate/unseeded BBS) SHALL be ignored and not counted as a drop.
REQ-011 The extracted bit SHALL be in_state[0]; bits SHALL shift in left, so the first accepted bit lands in out_word[W-1].
REQ-012 States SHALL be FILL (shift register filling, bit_cnt 0..W-1) and STALL (shift register full, output register occupied).
REQ-013 In FILL, on the W-th accepted bit: if out_valid=0 or out_ready=1 that cycle, out_word SHALL load {shift[W-2:0],bit}, out_valid SHALL be 1 next cycle, bit_cnt SHALL return to 0; otherwise the full word SHALL be held in the shift register and state SHALL go to STALL.
REQ-014 Latency: out_valid SHALL rise exactly one cycle after the clock edge accepting the W-th bit, when not stalled.
REQ-015 out_valid SHALL fall one cycle after an out_valid&&out_ready handshake, unless a new word loads in that same cycle (then it stays 1).
REQ-016 In STALL, every sample that REQ-010 would accept SHALL be dropped and SHALL increment drop_cnt, saturating at 16'hFFFF.
REQ-017 In STALL, on out_valid&&out_ready, out_word SHALL load the held word, out_valid stays 1, bit_cnt=0, state returns to FILL; a sample arriving that same cycle SHALL be dropped and counted.
REQ-018 out_word SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-019 Reset SHALL force state=FILL, bit_cnt=0, shift register=0, out_word=0, out_valid=0, drop_cnt=0, immediately and asynchronously, including mid-word and in STALL.
REQ-020 The first word after reset release SHALL contain only bits accepted after release.

Configuration
REQ-021 Macro BBS_PACK_VN_EN: when defined, accepted bits SHALL pass a von Neumann debiaser before packing: non-overlapping pairs (a,b); a!=b emits a; a==b emits nothing; an odd pending bit is cleared on reset and on any drop.
REQ-022 Without BBS_PACK_VN_EN, every accepted bit SHALL be packed directly and no pairing logic SHALL be synthesised.
REQ-023 In VN mode, REQ-013/REQ-016 SHALL apply to emitted bits; in STALL raw samples are still dropped and counted.

Structure
REQ-024 A shared package bbs_pkg SHALL hold the FILL/STALL state encoding, the drop_cnt width (16) and the default W (16), also used by bbs.
REQ-025 The von Neumann debiaser SHALL be one sub-module, bbs_vn_debias (in bit/valid, out bit/valid, clear), instantiated only under BBS_PACK_VN_EN.

Verification
REQ-026 out_ready=1; 16 samples alternating in_state=1,2 -> out_word=16'hAAAA, out_valid=1 one cycle after 16th sample, drop_cnt=0.
REQ-027 in_valid=1 with in_state=0 for 20 cycles, then 16 samples of value 3 -> only the latter counted; out_word=16'hFFFF.
REQ-028 out_ready=0; 37 samples of value 5 -> out_word=16'hFFFF held, STALL entered, drop_cnt=5; out_ready=1 one cycle -> out_word=16'hFFFF (second word), out_valid stays 1, state FILL.
REQ-029 out_valid=1, out_ready=1 in the same cycle the 16th bit of the next word arrives -> new word loads, no drop, out_valid continuously 1.
REQ-030 Assert reset after 8 samples and again while in STALL -> all outputs zero immediately; next word needs 16 fresh samples; drop_cnt=0.
REQ-031 With BBS_PACK_VN_EN, 64 samples with LSB pattern 0,1,1,0,1,1,0,0 repeated -> 16 emitted bits 0,1 repeated -> out_word=16'h5555.
